// File: rtl/crc_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : crc_frame_scheduler
// Brief    : Round-robin scheduler that shares one CRC generator between
//            NUM_SRC RS-coded byte streams. It captures one frame of exactly
//            RS_CNT bytes (padding short frames, truncating long ones), bursts
//            it gap-free to the CRC generator, then waits for the CRC output
//            frame to finish (or time out) before serving the next source.
// Revision : 1.0 - initial release
// ============================================================================
module crc_frame_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int RS_CNT       = 236,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         s_axis_tvalid,
  output logic [NUM_SRC-1:0]         s_axis_tready,
  input  logic [8*NUM_SRC-1:0]       s_axis_tdata,
  input  logic [NUM_SRC-1:0]         s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tlast,
  input  logic                       crc_out_tvalid,
  input  logic                       crc_out_tready,
  input  logic                       crc_out_tlast,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [31:0]                frame_cnt,
  output logic                       len_err,
  output logic                       timeout_err
);

  localparam int c_gw = $clog2(NUM_SRC);
  localparam int c_iw = $clog2(RS_CNT + 1);
  localparam int c_tw = ($clog2(DONE_TIMEOUT) < 1) ? 1 : $clog2(DONE_TIMEOUT);

  localparam logic [c_iw-1:0] c_last_idx = c_iw'(RS_CNT - 1);
  localparam logic [c_iw-1:0] c_full_idx = c_iw'(RS_CNT);
  localparam logic [c_tw-1:0] c_to_last  = c_tw'(DONE_TIMEOUT - 1);
  localparam logic [c_gw-1:0] c_src_last = c_gw'(NUM_SRC - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PAD       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_BURST     = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [c_gw-1:0]   r_rr;
  logic [c_gw-1:0]   r_grant;
  logic [c_iw-1:0]   r_wr_idx;
  logic [c_iw-1:0]   r_rd_idx;
  logic [c_tw-1:0]   r_to_cnt;
  logic [7:0]        r_buf [RS_CNT];
  logic              r_m_tvalid;
  logic [7:0]        r_m_tdata;
  logic              r_m_tlast;
  logic [31:0]       r_frame_cnt;
  logic              r_len_err;
  logic              r_timeout_err;

  logic              w_req_any;
  logic [c_gw-1:0]   w_pick;
  logic [c_gw-1:0]   w_cand;
  logic              w_tready_en;
  logic              w_src_valid;
  logic              w_src_last;
  logic [7:0]        w_src_byte;
  logic              w_src_hs;
  logic              w_m_hs;
  logic              w_crc_done;
  logic              w_buf_we;
  logic [7:0]        w_buf_wdata;
  logic              w_len_err;
  logic              w_timeout;
  logic              w_frame_done;

  // Granted-source view and handshake qualifiers
  assign w_tready_en = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign w_src_valid = s_axis_tvalid[r_grant];
  assign w_src_last  = s_axis_tlast[r_grant];
  assign w_src_byte  = s_axis_tdata[{r_grant, 3'b000} +: 8];
  assign w_src_hs    = w_tready_en & w_src_valid;
  assign w_m_hs      = r_m_tvalid & m_axis_tready;
  assign w_crc_done  = crc_out_tvalid & crc_out_tready & crc_out_tlast;

  // Buffer is filled by accepted source bytes in LOAD and by zeros in PAD
  assign w_buf_we    = ((r_state == ST_LOAD) && w_src_hs) || (r_state == ST_PAD);
  assign w_buf_wdata = (r_state == ST_PAD) ? 8'h00 : w_src_byte;

  assign s_axis_tready = w_tready_en ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_grant) : '0;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tlast  = r_m_tlast;
  assign grant_id      = r_grant;
  assign busy          = (r_state != ST_IDLE);
  assign frame_cnt     = r_frame_cnt;
  assign len_err       = r_len_err;
  assign timeout_err   = r_timeout_err;

  // Round-robin pick: scan offsets from highest to lowest so the requester
  // closest to the pointer is the last (winning) assignment
  always_comb begin
    w_req_any = 1'b0;
    w_pick    = '0;
    w_cand    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_cand = c_gw'((int'(r_rr) + k) % NUM_SRC);
      if (s_axis_tvalid[w_cand]) begin
        w_req_any = 1'b1;
        w_pick    = w_cand;
      end
    end
  end

  // Next-state decode plus the single-cycle event strobes
  always_comb begin
    w_state_next = r_state;
    w_len_err    = 1'b0;
    w_timeout    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_src_hs) begin
          if (w_src_last) begin
            if (r_wr_idx == c_last_idx) begin
              w_state_next = ST_BURST;
            end else begin
              w_len_err    = 1'b1;
              w_state_next = ST_PAD;
            end
          end else if (r_wr_idx == c_last_idx) begin
            w_len_err    = 1'b1;
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_PAD: begin
        if (r_wr_idx == c_last_idx) w_state_next = ST_BURST;
      end
      ST_DRAIN: begin
        if (w_src_hs && w_src_last) w_state_next = ST_BURST;
      end
      ST_BURST: begin
        if (w_m_hs && r_m_tlast) w_state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_crc_done) begin
          w_frame_done = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_to_cnt == c_to_last) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Grant/pointer bookkeeping, frame counter and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr          <= '0;
      r_grant       <= '0;
      r_frame_cnt   <= '0;
      r_len_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_len_err     <= w_len_err;
      r_timeout_err <= w_timeout;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 32'd1;
      if ((r_state == ST_IDLE) && w_req_any) begin
        r_grant <= w_pick;
        r_rr    <= (w_pick == c_src_last) ? '0 : w_pick + 1'b1;
      end
    end
  end

  // Frame buffer write port; contents need no reset
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_wr_idx] <= w_buf_wdata;
  end

  // Write index (zeroed while idle so every LOAD starts at 0) and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx <= '0;
      r_to_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE) r_wr_idx <= '0;
      else if (w_buf_we)      r_wr_idx <= r_wr_idx + 1'b1;
      r_to_cnt <= (r_state == ST_WAIT_DONE) ? r_to_cnt + 1'b1 : '0;
    end
  end

  // Output register: refill on every accepted byte so the burst has no bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_idx   <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= 8'h00;
      r_m_tlast  <= 1'b0;
    end else if (r_state != ST_BURST) begin
      r_rd_idx   <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (!r_m_tvalid || m_axis_tready) begin
      if (r_m_tvalid && r_m_tlast) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
      end else if (r_rd_idx != c_full_idx) begin
        r_m_tdata  <= r_buf[r_rd_idx];
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= (r_rd_idx == c_last_idx);
        r_rd_idx   <= r_rd_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_frame_scheduler
// Brief    : Scoreboard bench for crc_frame_scheduler. Source queues feed the
//            byte streams, expected burst bytes are queued when stimulus is
//            built and retired on every m_axis handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_frame_scheduler;

  localparam int NUM_SRC      = 4;
  localparam int RS_CNT       = 236;
  localparam int DONE_TIMEOUT = 16;
  localparam int CRC_DELAY    = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_SRC-1:0]   s_axis_tvalid;
  logic [NUM_SRC-1:0]   s_axis_tready;
  logic [8*NUM_SRC-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]   s_axis_tlast;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tlast;
  logic                 crc_out_tvalid;
  logic                 crc_out_tready;
  logic                 crc_out_tlast;
  logic [1:0]           grant_id;
  logic                 busy;
  logic [31:0]          frame_cnt;
  logic                 len_err;
  logic                 timeout_err;

  crc_frame_scheduler #(
    .NUM_SRC      (NUM_SRC),
    .RS_CNT       (RS_CNT),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .crc_out_tvalid (crc_out_tvalid),
    .crc_out_tready (crc_out_tready),
    .crc_out_tlast  (crc_out_tlast),
    .grant_id       (grant_id),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .len_err        (len_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] src_q [NUM_SRC][$];
  logic [8:0] exp_q [$];
  logic [1:0] grant_log [$];
  bit         gap_en     = 1'b0;
  bit         toggle_rdy = 1'b0;
  bit         crc_en     = 1'b1;
  int         cyc        = 0;
  int         len_err_cnt = 0;
  int         to_err_cnt  = 0;
  int         to_delay    = 0;
  logic       busy_after_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_tready"}, 32'(s_axis_tready), 0);
    check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 0);
    check({tag, "_m_tlast"},  32'(m_axis_tlast),  0);
    check({tag, "_m_tdata"},  32'(m_axis_tdata),  0);
    check({tag, "_grant_id"}, 32'(grant_id),      0);
    check({tag, "_busy"},     32'(busy),          0);
    check({tag, "_frame_cnt"}, frame_cnt,         0);
    check({tag, "_len_err"},  32'(len_err),       0);
    check({tag, "_to_err"},   32'(timeout_err),   0);
  endtask

  task automatic clear_queues();
    for (int s = 0; s < NUM_SRC; s++) src_q[s].delete();
    exp_q.delete();
    grant_log.delete();
    len_err_cnt = 0;
    to_err_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_queues();
    repeat (2) @(negedge clk);
    clear_queues();
    reset = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while ((frame_cnt < 32'(n)) && (t < budget)) begin
      @(negedge clk);
      t++;
    end
    if (frame_cnt < 32'(n)) check("wait_frames", frame_cnt, 32'(n));
    repeat (4) @(negedge clk);
  endtask

  // Bus-functional process: all driving and sampling happens on the falling edge
  initial begin : bfm
    logic [NUM_SRC-1:0] hs_prev;
    logic [8:0]         e;
    logic [8:0]         prev_out;
    bit                 in_frame, waiting_crc, prev_stall;
    logic               prev_busy;
    int                 crc_cd, end_stamp;
    hs_prev = '0; prev_out = '0; in_frame = 0; waiting_crc = 0; prev_stall = 0;
    prev_busy = 1'b0; crc_cd = 0; end_stamp = 0;
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0;
    m_axis_tready = 1'b1;
    crc_out_tvalid = 1'b0; crc_out_tready = 1'b0; crc_out_tlast = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (hs_prev[s] && (src_q[s].size() > 0)) src_q[s].delete(0);
        if ((src_q[s].size() > 0) && !(gap_en && ($urandom_range(0, 3) == 0))) begin
          e = src_q[s][0];
          s_axis_tvalid[s]        = 1'b1;
          s_axis_tdata[8*s +: 8]  = e[7:0];
          s_axis_tlast[s]         = e[8];
        end else begin
          s_axis_tvalid[s]        = 1'b0;
          s_axis_tdata[8*s +: 8]  = 8'h00;
          s_axis_tlast[s]         = 1'b0;
        end
      end
      hs_prev = reset ? '0 : (s_axis_tvalid & s_axis_tready);
      m_axis_tready = toggle_rdy ? ~m_axis_tready : 1'b1;
      crc_out_tvalid = 1'b0; crc_out_tready = 1'b0; crc_out_tlast = 1'b0;
      if (reset) begin
        in_frame = 0; waiting_crc = 0; prev_stall = 0; crc_cd = 0; prev_busy = 1'b0;
      end else begin
        if (waiting_crc) check("no_grant_wait", 32'(s_axis_tready), 0);
        if (crc_cd > 0) begin
          crc_cd--;
          if (crc_cd == 0) begin
            crc_out_tvalid = 1'b1; crc_out_tready = 1'b1; crc_out_tlast = 1'b1;
            waiting_crc = 0;
          end
        end
        if (prev_stall)
          check("hold_stable", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'({1'b1, prev_out}));
        if (in_frame) check("tvalid_hold", 32'(m_axis_tvalid), 1);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'({m_axis_tlast, m_axis_tdata}), 32'h1ff);
          end else begin
            check("m_byte", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_q[0]));
            exp_q.delete(0);
          end
          in_frame = !m_axis_tlast;
          if (m_axis_tlast) begin
            waiting_crc = 1;
            crc_cd      = crc_en ? CRC_DELAY : 0;
            end_stamp   = cyc + 1;
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tlast, m_axis_tdata};
        if (len_err) len_err_cnt++;
        if (timeout_err) begin
          to_err_cnt++;
          to_delay      = cyc - end_stamp;
          busy_after_to = busy;
          waiting_crc   = 0;
        end
        if (busy && !prev_busy) grant_log.push_back(grant_id);
        prev_busy = busy;
      end
    end
  end

  // Test sequence
  initial begin : main
    int t;
    logic [1:0] exp_g [8];
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // Normal frame from source 0 with random source gaps
    gap_en = 1'b1;
    for (int i = 0; i < RS_CNT; i++) begin
      src_q[0].push_back({i == RS_CNT - 1, 8'(i)});
      exp_q.push_back({i == RS_CNT - 1, 8'(i)});
    end
    wait_frames(1, 3000);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_len_err", 32'(len_err_cnt), 0);
    check("t1_sb_empty", 32'(exp_q.size()), 0);
    check("t1_grants", 32'(grant_log.size()), 1);
    if (grant_log.size() > 0) check("t1_grant0", 32'(grant_log[0]), 0);

    // All four sources requesting continuously, two frames each
    do_reset();
    gap_en = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < NUM_SRC; s++) begin
        exp_g[f*NUM_SRC + s] = 2'(s);
        for (int i = 0; i < RS_CNT; i++) begin
          src_q[s].push_back({i == RS_CNT - 1, 8'(s*64 + f*32 + i)});
          exp_q.push_back({i == RS_CNT - 1, 8'(s*64 + f*32 + i)});
        end
      end
    wait_frames(8, 6000);
    check("t2_frame_cnt", frame_cnt, 8);
    check("t2_len_err", 32'(len_err_cnt), 0);
    check("t2_sb_empty", 32'(exp_q.size()), 0);
    check("t2_grants", 32'(grant_log.size()), 8);
    for (int k = 0; k < 8; k++)
      if (k < grant_log.size()) check("t2_grant_seq", 32'(grant_log[k]), 32'(exp_g[k]));

    // Short frame from source 2: 100 x 0xA5, zero padded
    do_reset();
    for (int i = 0; i < 100; i++) src_q[2].push_back({i == 99, 8'hA5});
    for (int i = 0; i < RS_CNT; i++) exp_q.push_back({i == RS_CNT - 1, (i < 100) ? 8'hA5 : 8'h00});
    wait_frames(1, 3000);
    check("t3_frame_cnt", frame_cnt, 1);
    check("t3_len_err", 32'(len_err_cnt), 1);
    check("t3_sb_empty", 32'(exp_q.size()), 0);

    // Long frame from source 1 (300 bytes), source 3 waiting behind it
    do_reset();
    for (int i = 0; i < 300; i++) src_q[1].push_back({i == 299, 8'(i)});
    for (int i = 0; i < RS_CNT; i++) src_q[3].push_back({i == RS_CNT - 1, 8'(i) ^ 8'h3C});
    for (int i = 0; i < RS_CNT; i++) exp_q.push_back({i == RS_CNT - 1, 8'(i)});
    for (int i = 0; i < RS_CNT; i++) exp_q.push_back({i == RS_CNT - 1, 8'(i) ^ 8'h3C});
    wait_frames(2, 4000);
    check("t4_frame_cnt", frame_cnt, 2);
    check("t4_len_err", 32'(len_err_cnt), 1);
    check("t4_drained", 32'(src_q[1].size()), 0);
    check("t4_sb_empty", 32'(exp_q.size()), 0);
    check("t4_grants", 32'(grant_log.size()), 2);
    if (grant_log.size() > 1) begin
      check("t4_grant0", 32'(grant_log[0]), 1);
      check("t4_grant1", 32'(grant_log[1]), 3);
    end

    // Sink ready toggling every cycle during the burst
    do_reset();
    toggle_rdy = 1'b1;
    for (int i = 0; i < RS_CNT; i++) begin
      src_q[0].push_back({i == RS_CNT - 1, 8'(255 - i)});
      exp_q.push_back({i == RS_CNT - 1, 8'(255 - i)});
    end
    wait_frames(1, 3000);
    toggle_rdy = 1'b0;
    check("t5_frame_cnt", frame_cnt, 1);
    check("t5_sb_empty", 32'(exp_q.size()), 0);

    // CRC done never arrives: timeout path
    do_reset();
    crc_en = 1'b0;
    for (int i = 0; i < RS_CNT; i++) begin
      src_q[3].push_back({i == RS_CNT - 1, 8'(i * 3)});
      exp_q.push_back({i == RS_CNT - 1, 8'(i * 3)});
    end
    t = 0;
    while ((to_err_cnt == 0) && (t < 2000)) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    crc_en = 1'b1;
    check("t6_to_err_cnt", 32'(to_err_cnt), 1);
    check("t6_to_delay", 32'(to_delay), DONE_TIMEOUT);
    check("t6_frame_cnt", frame_cnt, 0);
    check("t6_idle", 32'(busy_after_to), 0);
    check("t6_sb_empty", 32'(exp_q.size()), 0);

    // Reset in the middle of LOAD
    do_reset();
    for (int i = 0; i < RS_CNT; i++) src_q[2].push_back({i == RS_CNT - 1, 8'(i)});
    t = 0;
    while ((s_axis_tready[2] !== 1'b1) && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    check("t7_busy_pre", 32'(busy), 1);
    check("t7_grant_pre", 32'(grant_id), 2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    clear_queues();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hang guard
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
